accumulator4_sequencer: RTL and testbench

Instruction sequencer that drives the accumulator4 datapath from a synchronous program memory.
- Fetches 13-bit instruction words and decodes them.
- Issues single-cycle enable pulses carrying the opcode and operand nybbles.
- Keeps the carry flag and feeds it back to the datapath.
- Executes its own branch and halt instructions.
- Evaluates zero and sign conditions from the returned accumulator value.

---
 rtl/accumulator4_pkg.sv | 39 +++
 rtl/accumulator4_branch_unit.sv | 25 ++
 rtl/accumulator4_sequencer.sv | 124 ++++++++++++
 tb/tb_accumulator4_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator4_pkg.sv
// Shared opcodes, FSM state encoding and instruction layout for the
// accumulator4 sequencer and its branch unit.
package accumulator4_pkg;

   localparam int INSTR_WIDTH = 13;

   localparam logic [4:0] OP_ADC  = 5'b10001;
   localparam logic [4:0] OP_ADD  = 5'b10010;
   localparam logic [4:0] OP_JMP  = 5'b11000;
   localparam logic [4:0] OP_JZ   = 5'b11001;
   localparam logic [4:0] OP_JC   = 5'b11010;
   localparam logic [4:0] OP_JS   = 5'b11011;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      HALT
   } state_t;

   typedef struct packed {
      logic [4:0] opcode;
      logic [3:0] hi;
      logic [3:0] lo;
   } instr_t;

   // Lower half: every opcode whose two LSBs are non-zero goes to the datapath.
   function automatic logic is_datapath_op(input logic [4:0] op);
      return ((op[4] == 1'b0) && (op[1:0] != 2'b00)) || (op == OP_ADC) || (op == OP_ADD);
   endfunction

   function automatic logic is_add_op(input logic [4:0] op);
      return (op == OP_ADC) || (op == OP_ADD);
   endfunction

endpackage

// File: rtl/accumulator4_branch_unit.sv
// Combinational branch decision: classifies the opcode and evaluates the
// zero, carry and sign conditions against the returned accumulator.
module accumulator4_branch_unit
   import accumulator4_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic [7:0] rx_accumulator,
   input  logic       carry_flag,
   output logic       take_branch,
   output logic       is_branch
);

   always_comb begin
      take_branch = 1'b0;
      is_branch   = 1'b1;
      case (opcode)
         OP_JMP:  take_branch = 1'b1;
         OP_JZ:   take_branch = (rx_accumulator == 8'h00);
         OP_JC:   take_branch = carry_flag;
         OP_JS:   take_branch = rx_accumulator[7];
         default: is_branch   = 1'b0;
      endcase
   end

endmodule

// File: rtl/accumulator4_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator4 datapath: reads a
// synchronous program memory, pulses datapath enables and runs local branches.
module accumulator4_sequencer
   import accumulator4_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int RESET_PC = 0
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         rx_run,
   output logic                         tx_mem_en,
   output logic [PC_WIDTH-1:0]          tx_pc,
   input  logic [INSTR_WIDTH-1:0]       rx_instr,
   output logic                         tx_enable,
   output logic [4:0]                   tx_opcode,
   output logic [3:0]                   tx_operand_hi,
   output logic [3:0]                   tx_operand_lo,
   output logic                         tx_carry,
   input  logic [7:0]                   rx_accumulator,
   input  logic                         rx_carry,
   output logic                         tx_busy,
   output logic                         tx_halted
);

   localparam logic [PC_WIDTH-1:0] RESET_PC_VAL = PC_WIDTH'(RESET_PC);
   localparam logic [PC_WIDTH-1:0] PC_ONE       = PC_WIDTH'(1);

   state_t              state_reg, state_next;
   logic [PC_WIDTH-1:0] pc_reg, pc_next;
   instr_t              ir_reg, ir_next;
   logic                carry_reg, carry_next;
   logic                take_branch, is_branch;
   logic                is_halt, is_add;

   assign is_halt = (ir_reg.opcode == OP_HALT);
   assign is_add  = is_add_op(ir_reg.opcode);

   accumulator4_branch_unit u_branch (
      .opcode         (ir_reg.opcode),
      .rx_accumulator (rx_accumulator),
      .carry_flag     (carry_reg),
      .take_branch    (take_branch),
      .is_branch      (is_branch)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC_VAL;
         ir_reg    <= '0;
         carry_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         carry_reg <= carry_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (rx_run) state_next = FETCH;
         FETCH:     state_next = DECODE;
         DECODE:    state_next = EXECUTE;
         EXECUTE: begin
            if (is_halt)     state_next = HALT;
            else if (is_add) state_next = WRITEBACK;
            else             state_next = rx_run ? FETCH : IDLE;
         end
         WRITEBACK: state_next = rx_run ? FETCH : IDLE;
         HALT:      if (!rx_run) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // PC, instruction register and carry flag updates.
   always_comb begin
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      carry_next = carry_reg;
      case (state_reg)
         DECODE: ir_next = instr_t'(rx_instr);
         EXECUTE: begin
            if (!is_halt) begin
               if (is_branch && take_branch) pc_next = ir_reg[PC_WIDTH-1:0];
               else                          pc_next = pc_reg + PC_ONE;
            end
         end
         WRITEBACK: carry_next = rx_carry;
         HALT:      if (!rx_run) pc_next = RESET_PC_VAL;
         default:   ;
      endcase
   end

   always_comb begin
      tx_mem_en = 1'b0;
      tx_enable = 1'b0;
      tx_busy   = 1'b0;
      tx_halted = 1'b0;
      case (state_reg)
         FETCH: begin
            tx_mem_en = 1'b1;
            tx_busy   = 1'b1;
         end
         DECODE:    tx_busy = 1'b1;
         EXECUTE: begin
            tx_busy   = 1'b1;
            tx_enable = is_datapath_op(ir_reg.opcode);
         end
         WRITEBACK: tx_busy   = 1'b1;
         HALT:      tx_halted = 1'b1;
         default:   ;
      endcase
   end

   assign tx_pc         = pc_reg;
   assign tx_opcode     = ir_reg.opcode;
   assign tx_operand_hi = ir_reg.hi;
   assign tx_operand_lo = ir_reg.lo;
   assign tx_carry      = carry_reg;

endmodule

// File: tb/tb_accumulator4_sequencer.sv
// Bench for accumulator4_sequencer: a per-instruction vector table drives an
// 8-bit-PC instance; hand sequences cover halt, pause, reset and PC wrap.
module tb_accumulator4_sequencer;
   import accumulator4_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn, rx_run, run_b;
   logic        tx_mem_en, tx_enable, tx_carry, tx_busy, tx_halted;
   logic [7:0]  tx_pc;
   logic [12:0] rx_instr = '0;
   logic [4:0]  tx_opcode;
   logic [3:0]  tx_operand_hi, tx_operand_lo;
   logic [7:0]  dp_acc, dp_b;
   logic        dp_c;

   logic        mem_en_b, enable_b, carry_b, busy_b, halted_b;
   logic [3:0]  pc_b, hi_b, lo_b;
   logic [4:0]  opcode_b;
   logic [12:0] instr_b = '0;

   logic [12:0] mem_a [256];
   logic [12:0] mem_b [16];

   int total  = 0;
   int passed = 0;

   always #5 aclk = ~aclk;

   accumulator4_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
      .aclk(aclk), .aresetn(aresetn), .rx_run(rx_run),
      .tx_mem_en(tx_mem_en), .tx_pc(tx_pc), .rx_instr(rx_instr),
      .tx_enable(tx_enable), .tx_opcode(tx_opcode),
      .tx_operand_hi(tx_operand_hi), .tx_operand_lo(tx_operand_lo),
      .tx_carry(tx_carry), .rx_accumulator(dp_acc), .rx_carry(dp_c),
      .tx_busy(tx_busy), .tx_halted(tx_halted)
   );

   accumulator4_sequencer #(.PC_WIDTH(4), .RESET_PC(0)) dut_b (
      .aclk(aclk), .aresetn(aresetn), .rx_run(run_b),
      .tx_mem_en(mem_en_b), .tx_pc(pc_b), .rx_instr(instr_b),
      .tx_enable(enable_b), .tx_opcode(opcode_b),
      .tx_operand_hi(hi_b), .tx_operand_lo(lo_b),
      .tx_carry(carry_b), .rx_accumulator(8'h00), .rx_carry(1'b0),
      .tx_busy(busy_b), .tx_halted(halted_b)
   );

   // Synchronous program memories: data valid the cycle after the strobe.
   always @(posedge aclk) if (tx_mem_en) rx_instr <= mem_a[tx_pc];
   always @(posedge aclk) if (mem_en_b) instr_b <= mem_b[pc_b];

   // Datapath model: LD loads A, LDC loads B, ADC/ADD add B (plus carry).
   always @(posedge aclk) begin
      if (!aresetn) begin
         dp_acc <= 8'h00;
         dp_b   <= 8'h00;
         dp_c   <= 1'b0;
      end else if (tx_enable) begin
         case (tx_opcode)
            5'b00011: dp_acc <= {tx_operand_hi, tx_operand_lo};
            5'b01011: dp_b   <= {tx_operand_hi, tx_operand_lo};
            5'b10001: {dp_c, dp_acc} <= {1'b0, dp_acc} + {1'b0, dp_b} + {8'h00, tx_carry};
            5'b10010: {dp_c, dp_acc} <= {1'b0, dp_acc} + {1'b0, dp_b};
            default: ;
         endcase
      end
   end

   typedef struct {
      logic [7:0]  addr;
      logic [12:0] instr;
      logic        en;
      logic [7:0]  next_pc;
      logic        carry;
      int          cycles;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_fetch(input string name);
      for (int n = 0; n < 10 && !tx_mem_en; n++) step();
      chk(name, {31'd0, tx_mem_en}, 32'd1);
   endtask

   task automatic wait_fetch_b(input string name);
      for (int n = 0; n < 10 && !mem_en_b; n++) step();
      chk(name, {31'd0, mem_en_b}, 32'd1);
   endtask

   initial begin
      int          cyc, en_cnt;
      logic [12:0] seen;
      logic        done;

      vecs[0]  = '{8'h00, {5'b00011, 8'hF0}, 1'b1, 8'h01, 1'b0, 3};
      vecs[1]  = '{8'h01, {5'b01011, 8'h20}, 1'b1, 8'h02, 1'b0, 3};
      vecs[2]  = '{8'h02, {5'b10001, 8'h00}, 1'b1, 8'h03, 1'b1, 4};
      vecs[3]  = '{8'h03, {5'b11010, 8'h07}, 1'b0, 8'h07, 1'b1, 3};
      vecs[4]  = '{8'h07, {5'b00011, 8'h00}, 1'b1, 8'h08, 1'b1, 3};
      vecs[5]  = '{8'h08, {5'b11001, 8'h0C}, 1'b0, 8'h0C, 1'b1, 3};
      vecs[6]  = '{8'h0C, {5'b00011, 8'h01}, 1'b1, 8'h0D, 1'b1, 3};
      vecs[7]  = '{8'h0D, {5'b11001, 8'h20}, 1'b0, 8'h0E, 1'b1, 3};
      vecs[8]  = '{8'h0E, {5'b00011, 8'h80}, 1'b1, 8'h0F, 1'b1, 3};
      vecs[9]  = '{8'h0F, {5'b11011, 8'h19}, 1'b0, 8'h19, 1'b1, 3};
      vecs[10] = '{8'h19, {5'b10010, 8'h00}, 1'b1, 8'h1A, 1'b0, 4};
      vecs[11] = '{8'h1A, {5'b11010, 8'h30}, 1'b0, 8'h1B, 1'b0, 3};
      vecs[12] = '{8'h1B, {5'b00100, 8'hAB}, 1'b0, 8'h1C, 1'b0, 3};
      vecs[13] = '{8'h1C, {5'b11111, 8'h00}, 1'b0, 8'h1C, 1'b0, 3};

      for (int i = 0; i < 256; i++) mem_a[i] = '0;
      for (int i = 0; i < NVEC; i++) mem_a[vecs[i].addr] = vecs[i].instr;
      for (int i = 0; i < 16; i++) mem_b[i] = '0;
      mem_b[0] = {5'b11000, 8'hFF};

      aresetn = 1'b0;
      rx_run  = 1'b0;
      run_b   = 1'b0;
      repeat (3) step();
      chk("reset_ctl", {28'd0, tx_mem_en, tx_enable, tx_busy, tx_halted}, 32'd0);
      chk("reset_pc", {24'd0, tx_pc}, 32'd0);
      chk("reset_ir", {19'd0, tx_opcode, tx_operand_hi, tx_operand_lo}, 32'd0);
      chk("reset_carry", {31'd0, tx_carry}, 32'd0);
      chk("reset_b", {27'd0, mem_en_b, pc_b}, 32'd0);
      aresetn = 1'b1;
      step();
      rx_run = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         wait_fetch("fetch_timeout");
         chk("fetch_pc", {24'd0, tx_pc}, {24'd0, vecs[i].addr});
         cyc    = 1;
         en_cnt = 0;
         seen   = '0;
         done   = 1'b0;
         for (int n = 0; n < 12 && !done; n++) begin
            step();
            if (tx_mem_en || tx_halted) done = 1'b1;
            else begin
               cyc++;
               if (tx_enable) begin
                  en_cnt++;
                  seen = {tx_opcode, tx_operand_hi, tx_operand_lo};
               end
            end
         end
         chk("latency", cyc, vecs[i].cycles);
         chk("enable_count", en_cnt, {31'd0, vecs[i].en});
         if (vecs[i].en) chk("enable_fields", {19'd0, seen}, {19'd0, vecs[i].instr});
         chk("halted", {31'd0, tx_halted}, {31'd0, vecs[i].instr[12:8] == OP_HALT});
         chk("next_pc", {24'd0, tx_pc}, {24'd0, vecs[i].next_pc});
         chk("carry", {31'd0, tx_carry}, {31'd0, vecs[i].carry});
         $display("instr @%02h word=%04h cycles=%0d enables=%0d pc->%02h carry=%0b",
                  vecs[i].addr, vecs[i].instr, cyc, en_cnt, tx_pc, tx_carry);
      end

      // HALT holds with no fetches or enables until run drops.
      for (int n = 0; n < 10; n++) begin
         step();
         chk("halt_hold", {29'd0, tx_mem_en, tx_enable, tx_halted}, 32'd1);
      end
      rx_run = 1'b0;
      step();
      chk("halt_exit_ctl", {29'd0, tx_halted, tx_busy, tx_mem_en}, 32'd0);
      chk("halt_exit_pc", {24'd0, tx_pc}, 32'd0);
      $display("halt released: pc=%02h", tx_pc);

      // Pause during DECODE: LD at 0 still completes, then IDLE at PC 1.
      rx_run = 1'b1;
      step();
      chk("pause_fetch_pc", {24'd0, tx_pc}, 32'd0);
      step();
      rx_run = 1'b0;
      step();
      chk("pause_exec_enable", {31'd0, tx_enable}, 32'd1);
      step();
      chk("pause_idle_busy", {30'd0, tx_busy, tx_mem_en}, 32'd0);
      chk("pause_idle_pc", {24'd0, tx_pc}, 32'd1);
      step();
      chk("pause_hold_pc", {23'd0, tx_mem_en, tx_pc}, 32'd1);
      $display("paused: pc=%02h busy=%0b", tx_pc, tx_busy);

      rx_run = 1'b1;
      step();
      chk("resume_pc", {23'd0, tx_mem_en, tx_pc}, 32'h101);
      step();
      wait_fetch("resume_fetch2");
      chk("resume_pc2", {24'd0, tx_pc}, 32'd2);
      step();
      wait_fetch("resume_fetch3");
      chk("resume_pc3", {24'd0, tx_pc}, 32'd3);
      chk("adc_carry", {31'd0, tx_carry}, 32'd1);

      // Reset asserted while the JC at address 3 is in EXECUTE.
      step();
      step();
      chk("jc_in_execute", {26'd0, tx_busy, tx_opcode}, {26'd1, OP_JC});
      aresetn = 1'b0;
      step();
      chk("midreset_ctl", {28'd0, tx_mem_en, tx_enable, tx_busy, tx_halted}, 32'd0);
      chk("midreset_pc", {24'd0, tx_pc}, 32'd0);
      chk("midreset_carry", {31'd0, tx_carry}, 32'd0);
      chk("midreset_ir", {19'd0, tx_opcode, tx_operand_hi, tx_operand_lo}, 32'd0);
      $display("reset mid-execute: pc=%02h carry=%0b", tx_pc, tx_carry);
      aresetn = 1'b1;
      rx_run  = 1'b0;
      step();

      // 4-bit PC: JMP 0xFF truncates to 15, NOP at 15 wraps to 0.
      run_b = 1'b1;
      wait_fetch_b("wrap_fetch0");
      chk("wrap_pc0", {28'd0, pc_b}, 32'd0);
      step();
      wait_fetch_b("wrap_fetch15");
      chk("wrap_jmp_trunc", {28'd0, pc_b}, 32'd15);
      step();
      wait_fetch_b("wrap_fetch_next");
      chk("wrap_pc_zero", {28'd0, pc_b}, 32'd0);
      $display("wrap: pc_b=%0h", pc_b);
      run_b = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
